// File: rtl/seg_ex_pkg.sv
// Shared constants and segment/one-hot helpers for the 74HC595 display link.
package seg_ex_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DIGITS     = 8;

  // Segment codes, active-low, bit order dp,g,f,e,d,c,b,a
  localparam logic [7:0] SEG_CODE_0 = 8'hC0;
  localparam logic [7:0] SEG_CODE_1 = 8'hF9;
  localparam logic [7:0] SEG_CODE_2 = 8'hA4;
  localparam logic [7:0] SEG_CODE_3 = 8'hB0;
  localparam logic [7:0] SEG_CODE_4 = 8'h99;
  localparam logic [7:0] SEG_CODE_5 = 8'h92;
  localparam logic [7:0] SEG_CODE_6 = 8'h82;
  localparam logic [7:0] SEG_CODE_7 = 8'hF8;
  localparam logic [7:0] SEG_CODE_8 = 8'h80;
  localparam logic [7:0] SEG_CODE_9 = 8'h90;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [3:0] BCD_BAD    = 4'hF;

  // Polarity is normalised to active-low and dp is forced off before matching.
  function automatic logic [3:0] seg_to_bcd(input logic [7:0] seg, input logic active_low);
    logic [7:0] code;
    code = (active_low ? seg : ~seg) | 8'h80;
    case (code)
      SEG_CODE_0: seg_to_bcd = 4'd0;
      SEG_CODE_1: seg_to_bcd = 4'd1;
      SEG_CODE_2: seg_to_bcd = 4'd2;
      SEG_CODE_3: seg_to_bcd = 4'd3;
      SEG_CODE_4: seg_to_bcd = 4'd4;
      SEG_CODE_5: seg_to_bcd = 4'd5;
      SEG_CODE_6: seg_to_bcd = 4'd6;
      SEG_CODE_7: seg_to_bcd = 4'd7;
      SEG_CODE_8: seg_to_bcd = 4'd8;
      SEG_CODE_9: seg_to_bcd = 4'd9;
      default:    seg_to_bcd = BCD_BAD;
    endcase
  endfunction

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      idx = v[i] ? 3'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with a rising-edge pulse on the synchronized level.
module sync_edge_det
  import seg_ex_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic din,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain plus one extra flop for edge detection
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_r[SYNC_STAGES-1];
  assign rise     = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/seg_ex_capture.sv
// Receive side of the 74HC595 display link: rebuilds 16-bit frames and assembles BCD sweeps.
// Define SEG_CAP_ERR_CNT_EN to add the saturating err_cnt output.
module seg_ex_capture
  import seg_ex_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int TIMEOUT_CYC    = 1_000_000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        data_ser,
  input  logic        srclk,
  input  logic        rclk,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        frame_err,
  output logic        seg_err,
  output logic        link_idle
`ifdef SEG_CAP_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  localparam int             TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [4:0]     CNT_SAT  = 5'd17;
  localparam logic [4:0]     CNT_FULL = 5'(FRAME_BITS);
  localparam logic           ACT_LOW  = (SEG_ACTIVE_LOW != 0);

  logic ser_s, srclk_rise_s, rclk_rise_s;
  logic srclk_lvl_unused_s, rclk_lvl_unused_s, ser_rise_unused_s;

  logic [FRAME_BITS-1:0]     sr_r, sr_shift_s;
  logic [4:0]                bit_cnt_r, cnt_shift_s, cnt_nxt_s;
  logic [DIGITS-1:0]         seen_r, seen_nxt_s;
  logic [DIGITS-1:0][3:0]    dig_buf_r;
  logic [31:0]               data_out_r;
  logic                      data_valid_r, frame_err_r, seg_err_r, link_idle_r, idle_nxt_s;
  logic [TMO_W-1:0]          tmo_cnt_r, tmo_nxt_s;
  logic                      frame_ok_s, accept_s, frame_err_s, seg_err_s;
  logic                      tmo_hit_s, sweep_done_s;
  logic [2:0]                slot_s;
  logic [3:0]                digit_s;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_srclk (
    .sys_clk(sys_clk), .rst_n(rst_n), .din(srclk),
    .sync_out(srclk_lvl_unused_s), .rise(srclk_rise_s)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rclk (
    .sys_clk(sys_clk), .rst_n(rst_n), .din(rclk),
    .sync_out(rclk_lvl_unused_s), .rise(rclk_rise_s)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ser (
    .sys_clk(sys_clk), .rst_n(rst_n), .din(data_ser),
    .sync_out(ser_s), .rise(ser_rise_unused_s)
  );

  // Shift path; a latch in the same cycle sees the already-shifted value
  always_comb begin
    sr_shift_s  = sr_r;
    cnt_shift_s = bit_cnt_r;
    if (srclk_rise_s) begin
      sr_shift_s  = {sr_r[FRAME_BITS-2:0], ser_s};
      cnt_shift_s = (bit_cnt_r == CNT_SAT) ? CNT_SAT : bit_cnt_r + 5'd1;
    end else begin
      sr_shift_s  = sr_r;
      cnt_shift_s = bit_cnt_r;
    end
  end

  // Frame qualification on rclk rise
  always_comb begin
    frame_ok_s  = (cnt_shift_s == CNT_FULL) && is_onehot8(sr_shift_s[7:0]);
    slot_s      = onehot_idx(sr_shift_s[7:0]);
    digit_s     = seg_to_bcd(sr_shift_s[15:8], ACT_LOW);
    accept_s    = rclk_rise_s & frame_ok_s;
    frame_err_s = rclk_rise_s & ~frame_ok_s;
    seg_err_s   = accept_s & (digit_s == BCD_BAD);
  end

  // Sweep tracking and link timeout; timeout clears state once, on the cycle it expires
  always_comb begin
    tmo_hit_s    = ~rclk_rise_s & (tmo_cnt_r == TMO_LAST);
    sweep_done_s = (seen_r == 8'hFF);
    seen_nxt_s   = (sweep_done_s | tmo_hit_s) ? 8'h00 : seen_r;
    cnt_nxt_s    = cnt_shift_s;
    tmo_nxt_s    = tmo_cnt_r;
    idle_nxt_s   = link_idle_r;
    if (rclk_rise_s) begin
      cnt_nxt_s  = 5'd0;
      tmo_nxt_s  = '0;
      idle_nxt_s = 1'b0;
      if (accept_s) begin
        seen_nxt_s = seen_nxt_s | (8'h01 << slot_s);
      end else begin
        seen_nxt_s = seen_nxt_s;
      end
    end else if (tmo_hit_s) begin
      cnt_nxt_s  = 5'd0;
      tmo_nxt_s  = TMO_MAX;
      idle_nxt_s = 1'b1;
    end else begin
      tmo_nxt_s  = (tmo_cnt_r == TMO_MAX) ? TMO_MAX : tmo_cnt_r + TMO_ONE;
    end
  end

  // State and registered outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r         <= '0;
      bit_cnt_r    <= 5'd0;
      seen_r       <= 8'h00;
      dig_buf_r    <= '0;
      data_out_r   <= 32'h0000_0000;
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      seg_err_r    <= 1'b0;
      link_idle_r  <= 1'b1;
      tmo_cnt_r    <= '0;
    end else begin
      sr_r         <= sr_shift_s;
      bit_cnt_r    <= cnt_nxt_s;
      seen_r       <= seen_nxt_s;
      tmo_cnt_r    <= tmo_nxt_s;
      link_idle_r  <= idle_nxt_s;
      frame_err_r  <= frame_err_s;
      seg_err_r    <= seg_err_s;
      data_valid_r <= sweep_done_s;
      if (accept_s) begin
        dig_buf_r[slot_s] <= digit_s;
      end
      if (sweep_done_s) begin
        data_out_r <= dig_buf_r;
      end
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign frame_err  = frame_err_r;
  assign seg_err    = seg_err_r;
  assign link_idle  = link_idle_r;

`ifdef SEG_CAP_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  // Saturating count of frame and segment error pulses
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'h00;
    end else if ((frame_err_s | seg_err_s) && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'h01;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_seg_ex_capture.sv
// Randomized bench for seg_ex_capture against a frame-level model of the 595 receive link.
module tb_seg_ex_capture;

  localparam int SS  = 2;
  localparam int TMO = 1000;
  localparam int H   = SS + 2;

  logic        sys_clk  = 1'b0;
  logic        rst_n    = 1'b0;
  logic        data_ser = 1'b0;
  logic        srclk    = 1'b0;
  logic        rclk     = 1'b0;
  logic [31:0] data_out;
  logic        data_valid, frame_err, seg_err, link_idle;
`ifdef SEG_CAP_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  always #5 sys_clk = ~sys_clk;

  seg_ex_capture #(.SYNC_STAGES(SS), .SEG_ACTIVE_LOW(1), .TIMEOUT_CYC(TMO)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .data_ser(data_ser), .srclk(srclk), .rclk(rclk),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
    .seg_err(seg_err), .link_idle(link_idle)
`ifdef SEG_CAP_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef enum int {EV_FE, EV_SE, EV_DV} ev_kind_t;
  typedef struct { ev_kind_t kind; logic [31:0] data; } ev_t;
  ev_t exp_q[$];
  ev_t cur_ev;

  logic [7:0]  seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [15:0] m_sr;
  int          m_cnt;
  logic [7:0]  m_seen;
  logic [3:0]  m_buf [8];
  logic [31:0] exp_out;
  int          exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Which segments are lit (dp ignored), matched against the digit table
  function automatic logic [3:0] model_decode(input logic [7:0] seg);
    logic [3:0] r;
    r = 4'hF;
    for (int d = 0; d < 10; d++)
      if ((~seg & 8'h7F) == (~seg_tab[d] & 8'h7F)) r = 4'(d);
    return r;
  endfunction

  function automatic logic [31:0] kind_vec(input ev_kind_t k);
    return (k == EV_FE) ? 32'd4 : (k == EV_SE) ? 32'd2 : 32'd1;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_sr = 16'h0; m_cnt = 0; m_seen = 8'h0; exp_out = 32'h0; exp_err = 0;
    for (int k = 0; k < 8; k++) m_buf[k] = 4'h0;
  endtask

  task automatic m_bit(input logic b);
    m_sr = {m_sr[14:0], b};
    if (m_cnt < 17) m_cnt++;
  endtask

  task automatic m_latch();
    ev_t        e;
    logic [3:0] d;
    int         k;
    e.data = 32'h0;
    if (m_cnt != 16 || $countones(m_sr[7:0]) != 1) begin
      e.kind = EV_FE;
      exp_q.push_back(e);
    end else begin
      k = 0;
      for (int i = 0; i < 8; i++) if (m_sr[i]) k = i;
      d = model_decode(m_sr[15:8]);
      m_buf[k] = d;
      m_seen[k] = 1'b1;
      if (d == 4'hF) begin
        e.kind = EV_SE;
        exp_q.push_back(e);
      end
      if (m_seen == 8'hFF) begin
        e.kind = EV_DV;
        for (int i = 0; i < 8; i++) e.data[4*i +: 4] = m_buf[i];
        exp_q.push_back(e);
        m_seen = 8'h0;
      end
    end
    m_cnt = 0;
  endtask

  // Per-cycle comparison of every output pulse and the held data word
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (frame_err || seg_err || data_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'({frame_err, seg_err, data_valid}), 32'd0);
        end else begin
          cur_ev = exp_q.pop_front();
          check("pulse_kind", 32'({frame_err, seg_err, data_valid}), kind_vec(cur_ev.kind));
          if (cur_ev.kind == EV_DV) exp_out = cur_ev.data;
          else if (exp_err < 255) exp_err++;
        end
      end
      check("data_out", data_out, exp_out);
`ifdef SEG_CAP_ERR_CNT_EN
      check("err_cnt", 32'(err_cnt), 32'(exp_err));
`endif
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic drain();
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic drive_bit(input logic b, input bit with_latch);
    data_ser = b; srclk = 1'b0;
    wait_cyc(H);
    srclk = 1'b1;
    m_bit(b);
    if (with_latch) begin
      rclk = 1'b1;
      m_latch();
    end
    wait_cyc(H);
    if (with_latch) begin
      srclk = 1'b0; rclk = 1'b0;
      wait_cyc(H);
      drain();
    end
  endtask

  task automatic latch();
    srclk = 1'b0;
    wait_cyc(H);
    rclk = 1'b1;
    m_latch();
    wait_cyc(H);
    rclk = 1'b0;
    wait_cyc(H);
    drain();
  endtask

  task automatic send_frame(input logic [15:0] f, input int nbits, input bit same_cycle);
    logic [15:0] sh;
    sh = f;
    for (int i = 0; i < nbits; i++) begin
      drive_bit(sh[15], same_cycle && (i == nbits - 1));
      sh = {sh[14:0], 1'b0};
    end
    if (!same_cycle) latch();
  endtask

  function automatic logic [15:0] good_frame(input logic [7:0] seg, input int slot);
    return {seg, 8'(8'h01 << slot)};
  endfunction

  task automatic send_slots(input logic [31:0] val, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) send_frame(good_frame(seg_tab[val[4*k +: 4]], k), 16, 1'b0);
  endtask

  task automatic do_reset();
    srclk = 1'b0; rclk = 1'b0; data_ser = 1'b0; rst_n = 1'b0;
    model_clear();
    wait_cyc(3);
    check("rst_data_out", data_out, 32'h0);
    check("rst_pulses", 32'({frame_err, seg_err, data_valid}), 32'd0);
    check("rst_link_idle", 32'(link_idle), 32'd1);
`ifdef SEG_CAP_ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    wait_cyc(3);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] f;
    int          slot, pick, dg;
    do_reset();

    // In-order sweep, digits low first
    send_slots(32'h1234_5678, 0, 7);
    check("t1_data_out", data_out, 32'h1234_5678);
    check("t1_link_idle", 32'(link_idle), 32'd0);

    // Short frame, then a clean sweep
    send_frame(16'hC001, 15, 1'b0);
    send_slots(32'h8765_4321, 0, 7);
    check("t2_data_out", data_out, 32'h8765_4321);

    // Two digit-select bits set: rejected, buffer untouched
    send_slots(32'h5555_5599, 0, 6);
    send_frame(16'hC003, 16, 1'b0);
    send_slots(32'h5555_5599, 7, 7);
    check("t3_data_out", data_out, 32'h5555_5599);

    // Undecodable segment code on digit 2
    send_slots(32'h2222_2222, 0, 1);
    send_frame(good_frame(8'h88, 2), 16, 1'b0);
    send_slots(32'h2222_2222, 3, 7);
    check("t4_data_out", data_out, 32'h2222_2F22);

    // Same-cycle shift/latch, then link timeout drops partial progress
    send_slots(32'h9876_5432, 0, 1);
    send_frame(good_frame(seg_tab[4], 2), 16, 1'b1);
    for (int i = 0; i < 5; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
    wait_cyc(850);
    check("t5_not_idle_yet", 32'(link_idle), 32'd0);
    wait_cyc(250);
    check("t5_idle", 32'(link_idle), 32'd1);
    check("t5_held", data_out, 32'h2222_2F22);
    m_seen = 8'h0;
    m_cnt = 0;
    send_slots(32'h9876_5432, 3, 7);
    send_slots(32'h9876_5432, 0, 2);
    check("t5_data_out", data_out, 32'h9876_5432);
    check("t5_link_back", 32'(link_idle), 32'd0);

    // Randomized frames: repeats, dp, raw codes, malformed frames, same-cycle latches
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 12; j++) begin
        slot = $urandom_range(0, 7);
        pick = $urandom_range(0, 9);
        dg   = $urandom_range(0, 9);
        if (pick == 0) begin
          f = 16'($urandom());
          send_frame(f, $urandom_range(1, 20), 1'b0);
        end else if (pick == 1) begin
          send_frame(good_frame(8'($urandom_range(0, 255)), slot), 16, 1'b0);
        end else begin
          f = good_frame(($urandom_range(0, 1) == 1) ? (seg_tab[dg] & 8'h7F) : seg_tab[dg], slot);
          send_frame(f, 16, ($urandom_range(0, 3) == 0));
        end
      end
      for (int k = 0; k < 8; k++)
        if (!m_seen[k]) send_frame(good_frame(seg_tab[$urandom_range(0, 9)], k), 16, 1'b0);
    end

    // Reset in the middle of a frame
    for (int i = 0; i < 9; i++) drive_bit(1'b1, 1'b0);
    do_reset();
    send_slots(32'h1020_3040, 0, 7);
    check("t6_data_out", data_out, 32'h1020_3040);

    // Error storm
    for (int i = 0; i < 300; i++) send_frame(16'h0000, 1, 1'b0);
`ifdef SEG_CAP_ERR_CNT_EN
    check("t6_err_cnt_sat", 32'(err_cnt), 32'h0000_00FF);
`endif
    check("t6_data_hold", data_out, 32'h1020_3040);

    wait_cyc(10);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
